// File: rtl/int_gen.sv
// int_gen: memory-mapped periodic interrupt generator with ack and miss counting
module int_gen #(
    parameter logic [31:0] BASE = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q, state_d;
    logic [31:0] period_q, period_d, count_q, count_d, merged;
    logic [7:0]  miss_q, miss_d;
    logic        en_q, en_d, pend_q, pend_d;
    logic        hit, wr, wr_ack, wr_per, wr_sts, expire;
    always_comb begin
        hit    = addr[29:2] == BASE[31:4];
        wr     = hit && |byteen;
        wr_ack = wr && addr[1:0] == 2'd0;
        wr_per = wr && addr[1:0] == 2'd1;
        wr_sts = wr && addr[1:0] == 2'd3;
        merged = period_q;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : period_q[8*i +: 8];
        // a PERIOD write suppresses this cycle's expiry as well as the decrement
        expire   = state_q == RUN && count_q == 32'd1 && !wr_per;
        period_d = wr_per ? merged : period_q;
        count_d  = wr_per ? merged :
                   expire ? period_q :
                   (state_q == RUN && count_q > 32'd1) ? count_q - 32'd1 : count_q;
        en_d     = (wr_sts && byteen[0]) ? wdata[1] : en_q;
        pend_d   = expire | (pend_q & ~wr_ack);
        miss_d   = (wr_sts && byteen[1]) ? 8'd0 :
                   (expire && pend_q && !wr_ack && miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
        state_d  = (en_d && period_d != 32'd0) ? RUN : IDLE;
        rdata    = !hit ? 32'd0 :
                   addr[1:0] == 2'd0 ? {31'd0, pend_q} :
                   addr[1:0] == 2'd1 ? period_q :
                   addr[1:0] == 2'd2 ? count_q :
                   {16'd0, miss_q, 6'd0, en_q, pend_q};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            period_q <= 32'd0;
            count_q  <= 32'd0;
            miss_q   <= 8'd0;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            count_q  <= count_d;
            miss_q   <= miss_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
        end
    end
    assign irq = pend_q;
endmodule

// File: tb/tb_int_gen.sv
// tb_int_gen: scoreboard bench for int_gen; stimulus queues expectations, a monitor compares
module tb_int_gen;
    localparam logic [29:0] A_ACK = 30'h1FC8, A_PER = 30'h1FC9, A_CNT = 30'h1FCA, A_STS = 30'h1FCB, A_OUT = 30'h1FCC;
    logic        clk = 1'b0, reset = 1'b0, irq;
    logic [29:0] addr = 30'd0;
    logic [3:0]  byteen = 4'd0;
    logic [31:0] wdata = 32'd0, rdata;
    typedef struct { string name; bit is_irq; logic [31:0] exp; } exp_t;
    exp_t q[$];
    event sample_ev;
    int checks = 0, errors = 0;
    int_gen dut (.clk(clk), .reset(reset), .addr(addr), .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq));
    always #5 clk = ~clk;
    initial forever begin
        exp_t e;
        logic [31:0] act;
        @(sample_ev);
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: sample with no expectation queued");
        end else begin
            e = q.pop_front();
            act = e.is_irq ? {31'd0, irq} : rdata;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end
    task automatic rd(input string name, input logic [29:0] a, input logic [31:0] exp);
        exp_t e;
        addr = a;
        e.name = name; e.is_irq = 1'b0; e.exp = exp;
        q.push_back(e);
        ->sample_ev;
        #2;
    endtask
    task automatic chk_irq(input string name, input logic v);
        exp_t e;
        e.name = name; e.is_irq = 1'b1; e.exp = {31'd0, v};
        q.push_back(e);
        ->sample_ev;
        #2;
    endtask
    task automatic wr(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        @(posedge clk);
        #1 byteen = 4'd0;
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        tick(2);
        chk_irq("reset_irq", 1'b0);
        rd("reset_ack", A_ACK, 32'd0);
        rd("reset_period", A_PER, 32'd0);
        rd("reset_count", A_CNT, 32'd0);
        rd("reset_status", A_STS, 32'd0);
        reset = 1'b1;
        tick(1);
        wr(A_STS, 4'b0001, 32'd2);
        rd("enable_status", A_STS, 32'h2);
        wr(A_PER, 4'b1111, 32'd5);
        rd("count_load", A_CNT, 32'd5);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            rd($sformatf("count_dec%0d", k), A_CNT, 32'(5 - k));
            chk_irq($sformatf("irq_low%0d", k), 1'b0);
        end
        tick(1);
        chk_irq("irq_rise", 1'b1);
        rd("count_reload", A_CNT, 32'd5);
        rd("ack_reads_pend", A_ACK, 32'd1);
        wr(A_ACK, 4'b0001, 32'd0);
        chk_irq("ack_clears", 1'b0);
        tick(3);
        chk_irq("before_second", 1'b0);
        tick(1);
        chk_irq("second_expiry", 1'b1);
        rd("no_miss_yet", A_STS, 32'h3);
        tick(4);
        wr(A_ACK, 4'b0001, 32'd0);
        chk_irq("ack_vs_expiry", 1'b1);
        rd("ack_vs_expiry_miss", A_STS, 32'h3);
        wr(A_ACK, 4'b0001, 32'd0);
        chk_irq("ack_again", 1'b0);
        wr(A_PER, 4'b1111, 32'd3);
        tick(3);
        rd("p3_first", A_STS, 32'h003);
        tick(9);
        rd("miss_three", A_STS, 32'h303);
        wr(A_STS, 4'b0010, 32'd0);
        rd("miss_clear", A_STS, 32'h003);
        wr(A_PER, 4'b1111, 32'd1);
        tick(10);
        rd("miss_ten", A_STS, 32'h0A03);
        tick(290);
        rd("miss_sat", A_STS, 32'hFF03);
        chk_irq("p1_irq", 1'b1);
        wr(A_STS, 4'b0001, 32'd0);
        tick(3);
        rd("disabled_status", A_STS, 32'hFF01);
        rd("disabled_count", A_CNT, 32'd1);
        wr(A_PER, 4'b1111, 32'h0000_0100);
        rd("period_full", A_PER, 32'h0000_0100);
        wr(A_PER, 4'b0001, 32'hFFFF_FF10);
        rd("period_merge", A_PER, 32'h0000_0110);
        rd("merge_reload", A_CNT, 32'h0000_0110);
        wr(A_CNT, 4'b1111, 32'h0000_00AB);
        rd("count_ro", A_CNT, 32'h0000_0110);
        wr(A_OUT, 4'b1111, 32'h0000_1234);
        rd("outside_read", A_OUT, 32'd0);
        rd("outside_period", A_PER, 32'h0000_0110);
        chk_irq("outside_no_ack", 1'b1);
        wr(A_STS, 4'b0001, 32'd2);
        tick(2);
        rd("running_count", A_CNT, 32'h0000_010E);
        reset = 1'b0;
        chk_irq("midreset_irq", 1'b0);
        rd("midreset_count", A_CNT, 32'd0);
        rd("midreset_period", A_PER, 32'd0);
        rd("midreset_status", A_STS, 32'd0);
        tick(1);
        reset = 1'b1;
        tick(2);
        rd("post_reset_status", A_STS, 32'd0);
        #5;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_gen.md
# int_gen

Memory-mapped interrupt generator. It is the responder end of the CPU's interrupt-generator write port (the `m_int_addr` / `m_int_byteen` path) and produces the external `interrupt` line into `HWInt[2]`. It raises a level interrupt every programmed number of cycles, holds it until the handler writes the acknowledge register, and counts expiries that occur while an interrupt is still pending. It sits on the bridge data bus alongside the two TC timers and decodes its own 16-byte window.

## Interface
Parameters:
- `BASE`, default 32'h0000_7F20: byte base address of the 16-byte window; bits [3:0] must be 0.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `addr`  in  30  word address (byte address [31:2]) from the bridge.
- `byteen`  in  4  byte write enables; a write occurs when nonzero and `addr` hits the window.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr` and the current state.
- `irq`  out  1  interrupt request, registered level.

## Operation
- Hit: `addr[29:2] == BASE[31:4]`. Word offset is `addr[1:0]`. No hit means no write and `rdata` = 0.
- Registers:
  - Offset 0, ACK: a write with any lane set clears pending. Reads return {31'b0, pending}.
  - Offset 1, PERIOD (32-bit, RW): per-lane merge. A write also reloads COUNT from the merged value.
  - Offset 2, COUNT (RO): current down-counter. Writes are ignored.
  - Offset 3, STATUS: bit0 = pending (RO), bit1 = enable (RW via lane 0), bits [15:8] = miss count (any lane-1 write clears it to 0). Other bits read 0.
- State machine:
  - IDLE: entered when enable = 0 or PERIOD = 0.
  - RUN: entered when enable = 1 and PERIOD != 0.
  - Pending is an independent flag and is not a state.
- In RUN, each cycle:
  - If COUNT > 1, decrement COUNT.
  - If COUNT == 1 (expiry), reload COUNT to PERIOD, set pending, and increment miss count (saturating at 255) if pending was already 1.
- In IDLE, COUNT holds and pending holds.
- `irq` = pending flag (registered, no combinational path from the bus).
- Priority in one cycle:
  - A PERIOD write beats the decrement or reload.
  - An expiry beats an ACK write: pending stays 1 and the miss count is not incremented.
  - Writing enable = 0 freezes COUNT but does not clear pending.
- Arithmetic: COUNT and PERIOD are 32-bit unsigned. The miss counter is 8-bit saturating and never wraps.

## Timing
- Reset values (asynchronous, effective immediately): PERIOD = 0, COUNT = 0, enable = 0, pending = 0, miss = 0, `irq` = 0. `rdata` follows these values.
- Reset asserted mid-count or while pending clears everything. After release, the first edge behaves as IDLE.
- Writes take effect at the edge where `byteen` is sampled. Reads reflect state after the most recent edge.
- With enable = 1 and PERIOD = N written at edge E0, `irq` rises at edge E0 + N, then every N cycles.
- PERIOD = 1 expires every cycle. `irq` is then continuously 1 after the first expiry, and the miss count increments every cycle until it saturates.
- ACK written at edge Ea: `irq` is 0 after Ea, unless an expiry also occurs at Ea.

## Test plan
- Reset: hold `reset` = 0 mid-operation → `irq` = 0, all register reads = 0, independent of `clk`.
- Basic period: write STATUS = 2, then PERIOD = 5 → `irq` rises exactly 5 edges after the PERIOD write; COUNT reads 5,4,3,2,1 in between.
- Acknowledge: after `irq` = 1, write ACK with `byteen` = 4'b0001 → `irq` = 0 next cycle; it re-asserts 5 cycles after the prior expiry.
- Miss counting: PERIOD = 3, never ACK for 12 cycles → STATUS[15:8] = 3. Then write STATUS with `byteen` = 4'b0010 → miss = 0.
- Simultaneous ACK and expiry: ACK on the exact expiry edge → `irq` stays 1, miss unchanged.
- Lane merge and decode: PERIOD = 32'h0000_0100, then write 32'hFFFF_FF10 with `byteen` = 4'b0001 → PERIOD reads 32'h0000_0110. A write at BASE + 16 changes nothing.
